// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared definitions for the bit-serial subtractor: FSM state
//            encoding and the default operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Purpose  : One-bit full subtractor computing a - b - borrowInput.
// Ports    : a, b         - operand bits
//            borrowInput  - borrow from the less significant bit
//            diff         - difference bit
//            borrowOutput - borrow into the next more significant bit
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrowInput,
  output logic diff,
  output logic borrowOutput
);

  logic w_axb;

  assign w_axb        = a ^ b;
  assign diff         = w_axb ^ borrowInput;
  // Borrow when b exceeds a, or when the bits match and a borrow ripples in.
  assign borrowOutput = (~a & b) | (~w_axb & borrowInput);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned subtractor. Computes a - b one bit per
//            clock, LSB first, and presents the result with a done pulse.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            start      - begin a subtraction (accepted in IDLE or DONE)
//            a, b       - minuend / subtrahend, captured on start accept
//            busy       - high while bits are being processed
//            done       - one-cycle pulse, result valid
//            diff       - (a - b) mod 2^WIDTH, held until the next result
//            borrow_out - high when a < b (unsigned)
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_d;
  logic               w_borrow_next;
  logic [WIDTH-1:0]   w_res_next;

  full_subtractor u_fs (
    .a            (r_a[0]),
    .b            (r_b[0]),
    .borrowInput  (r_borrow),
    .diff         (w_d),
    .borrowOutput (w_borrow_next)
  );

  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_borrow   <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= SHIFT;
            busy     <= 1'b1;
          end else begin
            r_state  <= IDLE;
            busy     <= 1'b0;
          end
        end

        SHIFT: begin
          r_res    <= w_res_next;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            // Result is published only here, so partial sums never reach diff.
            r_state    <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= w_res_next;
            borrow_out <= w_borrow_next;
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8): directed
//            operand vectors, back-to-back start, reset abort and an
//            operand sweep against a reference difference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one subtraction from IDLE and check latency, busy length,
  // result and that diff held its old value until done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_b);
    int lat       = 0;
    int busy_cnt  = 0;
    bit seen      = 0;
    bit hold_bad  = 0;
    a     = av;
    b     = bv;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        break;
      end
      if (diff !== last_diff) hold_bad = 1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(W + 1));
    check("busy_len", 32'(busy_cnt), 32'(W));
    check("diff_hold", 32'(hold_bad), 32'd0);
    check("diff", 32'(diff), 32'(exp_d));
    check("borrow", 32'(borrow_out), 32'(exp_b));
    last_diff = exp_d;
  endtask

  typedef struct {
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] dv;
    logic         bo;
  } vec_t;

  vec_t vecs[7] = '{
    '{8'h5A, 8'h23, 8'h37, 1'b0},
    '{8'h00, 8'h01, 8'hFF, 1'b1},
    '{8'hFF, 8'hFF, 8'h00, 1'b0},
    '{8'h00, 8'hFF, 8'h01, 1'b1},
    '{8'hFF, 8'h00, 8'hFF, 1'b0},
    '{8'h80, 8'h7F, 8'h01, 1'b0},
    '{8'h7F, 8'h80, 8'hFF, 1'b1}
  };

  initial begin
    int lat;
    int pulses;
    bit seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;

    // Directed vectors; first start is offered right after reset release.
    foreach (vecs[i]) run_op(vecs[i].av, vecs[i].bv, vecs[i].dv, vecs[i].bo);

    // Result holds while idle.
    tick();
    tick();
    check("idle_done", 32'(done), 32'd0);
    check("idle_diff", 32'(diff), 32'(last_diff));

    // Start held high; operands change mid-operation.
    a = 8'h40;
    b = 8'h13;
    start = 1'b1;
    lat = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (lat == 1) begin
        a = 8'h77;
        b = 8'h01;
      end
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("b2b_done1", 32'(seen), 32'd1);
    check("b2b_lat1", 32'(lat), 32'd9);
    check("b2b_diff1", 32'(diff), 32'h2D);
    check("b2b_borrow1", 32'(borrow_out), 32'd0);
    lat = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        check("b2b_restart_busy", 32'(busy), 32'd1);
      end
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("b2b_done2", 32'(seen), 32'd1);
    check("b2b_lat2", 32'(lat), 32'd9);
    check("b2b_diff2", 32'(diff), 32'h76);
    check("b2b_borrow2", 32'(borrow_out), 32'd0);
    last_diff = 8'h76;
    tick();

    // Reset in the middle of SHIFT aborts without a done pulse.
    a = 8'h5A;
    b = 8'h23;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    last_diff = '0;
    run_op(8'h10, 8'h01, 8'h0F, 1'b0);

    // Operand sweep against the reference model.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      run_op(ra, rb, ra - rb, (ra < rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
